// File: rtl/game_sync_fsm_pkg.sv
// Shared types and default timing for the networked multiplayer sync controller.
package NetworkPkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAME_READY,
        ST_COUNTDOWN,
        ST_IN_GAME,
        ST_GAME_LOST,
        ST_GAME_WON
    } sync_state_t;

    localparam int DEF_NUM_OPP       = 3;
    localparam int DEF_READY_TIMEOUT = 50_000_000;
    localparam int DEF_COUNTDOWN     = 1_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/game_sync_fsm_popcount.sv
// Combinational population count of a W-bit vector.
module popcount #(
    parameter int W = 8
) (
    input  logic [W-1:0]             bits,
    output logic [$clog2(W+1)-1:0]   count
);
    localparam int CW = $clog2(W + 1);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/game_sync_fsm.sv
// Multiplayer handshake controller: ready sync with timeout, countdown, in-game
// opponent tracking and final placement.
module game_sync_fsm
    import NetworkPkg::*;
#(
    parameter int NUM_OPP       = DEF_NUM_OPP,
    parameter int READY_TIMEOUT = DEF_READY_TIMEOUT,
    parameter int COUNTDOWN     = DEF_COUNTDOWN
) (
    input  logic                          clk,
    input  logic                          rst_l,
    input  logic                          player_ready,
    input  logic                          player_unready,
    input  logic                          top_out,
    input  logic [NUM_OPP-1:0]            opp_ack,
    input  logic [NUM_OPP-1:0]            opp_lost,
    output logic                          send_ready_ACK,
    output logic                          send_game_lost,
    output logic                          game_active,
    output logic                          game_won,
    output logic [NUM_OPP-1:0]            opp_alive,
    output logic [$clog2(NUM_OPP+2)-1:0]  place,
    output logic                          ready_timeout
);
    localparam int TW = $clog2(max_int(READY_TIMEOUT, COUNTDOWN) + 1);
    localparam int PW = $clog2(NUM_OPP + 2);
    localparam int CW = $clog2(NUM_OPP + 1);

    localparam logic [NUM_OPP-1:0] ALL_OPP    = {NUM_OPP{1'b1}};
    localparam logic [TW-1:0]      READY_LAST = TW'(READY_TIMEOUT - 1);
    localparam logic [TW-1:0]      CD_LOAD    = TW'(COUNTDOWN - 1);
    localparam logic [TW-1:0]      TIMER_MAX  = {TW{1'b1}};

    sync_state_t         state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [NUM_OPP-1:0]  ack_seen_q, ack_seen_d;
    logic [NUM_OPP-1:0]  opp_alive_q, opp_alive_d;
    logic [PW-1:0]       place_q, place_d;
    logic [NUM_OPP-1:0]  survivors;
    logic [NUM_OPP-1:0]  acks_now;
    logic [CW-1:0]       survivor_cnt;
    logic                timeout_pulse;

    // Opponents still standing once this cycle's losses are applied.
    assign survivors = opp_alive_q & ~opp_lost;
    assign acks_now  = ack_seen_q | opp_ack;

    popcount #(
        .W (NUM_OPP)
    ) u_popcount (
        .bits  (survivors),
        .count (survivor_cnt)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            ack_seen_q  <= '0;
            opp_alive_q <= '0;
            place_q     <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            ack_seen_q  <= ack_seen_d;
            opp_alive_q <= opp_alive_d;
            place_q     <= place_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        ack_seen_d    = ack_seen_q;
        opp_alive_d   = opp_alive_q;
        place_d       = place_q;
        timeout_pulse = 1'b0;

        case (state_q)
            ST_IDLE: begin
                opp_alive_d = '0;
                if (player_ready) begin
                    state_d    = ST_GAME_READY;
                    ack_seen_d = '0;
                    place_d    = '0;
                    timer_d    = '0;
                end
            end

            ST_GAME_READY: begin
                ack_seen_d = acks_now;
                // A complete ack set beats a timeout landing in the same cycle.
                if (player_unready) begin
                    state_d = ST_IDLE;
                end else if (acks_now == ALL_OPP) begin
                    state_d = ST_COUNTDOWN;
                    timer_d = CD_LOAD;
                end else if (timer_q == READY_LAST) begin
                    state_d       = ST_IDLE;
                    timeout_pulse = 1'b1;
                end else if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + TW'(1);
                end
            end

            ST_COUNTDOWN: begin
                if (player_unready) begin
                    state_d = ST_IDLE;
                end else if (timer_q == '0) begin
                    state_d     = ST_IN_GAME;
                    opp_alive_d = ALL_OPP;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            ST_IN_GAME: begin
                opp_alive_d = survivors;
                // Local loss takes precedence; a simultaneous last knockout ties for first.
                if (top_out || player_unready) begin
                    state_d = ST_GAME_LOST;
                    place_d = PW'(survivor_cnt) + PW'(1);
                end else if (survivors == '0) begin
                    state_d = ST_GAME_WON;
                    place_d = PW'(1);
                end
            end

            ST_GAME_LOST: begin
                opp_alive_d = survivors;
                if (survivors == '0) begin
                    state_d = ST_IDLE;
                end
            end

            ST_GAME_WON: begin
                if (player_ready || player_unready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign send_ready_ACK = (state_q == ST_GAME_READY) || (state_q == ST_COUNTDOWN);
    assign send_game_lost = (state_q == ST_GAME_LOST);
    assign game_active    = (state_q == ST_IN_GAME);
    assign game_won       = (state_q == ST_GAME_WON);
    assign opp_alive      = opp_alive_q;
    assign place          = place_q;
    assign ready_timeout  = timeout_pulse;

endmodule

// File: doc/game_sync_fsm.md
GAME_SYNC_FSM -- requirements
Module: game_sync_fsm

Interface
REQ-001 SHALL have parameter NUM_OPP, default 3, number of networked opponents (1..7).
REQ-002 SHALL have parameter READY_TIMEOUT, default 50_000_000, max cycles in GAME_READY before abandon (>=2).
REQ-003 SHALL have parameter COUNTDOWN, default 1_000_000, cycles between all-ready and game start (>=1).
REQ-004 SHALL have port clk  input  1  single clock for all state; one clock, no other clock domains.
REQ-005 SHALL have port rst_l  input  1  reset; asynchronous and active-low.
REQ-006 SHALL have port player_ready  input  1  local player requests multiplayer game.
REQ-007 SHALL have port player_unready  input  1  local player cancels/leaves.
REQ-008 SHALL have port top_out  input  1  local player lost, from game logic.
REQ-009 SHALL have port opp_ack  input  NUM_OPP  per-opponent ready ACK, from receivers.
REQ-010 SHALL have port opp_lost  input  NUM_OPP  per-opponent game-lost, from receivers.
REQ-011 SHALL have port send_ready_ACK  output  1  drive ACK on handshake lines.
REQ-012 SHALL have port send_game_lost  output  1  drive game-lost on handshake lines.
REQ-013 SHALL have port game_active  output  1  game in progress.
REQ-014 SHALL have port game_won  output  1  local player last standing.
REQ-015 SHALL have port opp_alive  output  NUM_OPP  per-opponent still-playing flags.
REQ-016 SHALL have port place  output  $clog2(NUM_OPP+2)  final rank, 1 = winner, 0 = undecided.
REQ-017 SHALL have port ready_timeout  output  1  one-cycle pulse on ready abandon.

Function
REQ-018 SHALL implement states IDLE, GAME_READY, COUNTDOWN, IN_GAME, GAME_LOST, GAME_WON; outputs Moore (registered state only) except ready_timeout.
REQ-019 IDLE: all outputs 0 except place, which holds last result; player_ready -> GAME_READY, clearing ack_seen, place, and the timer.
REQ-020 GAME_READY: send_ready_ACK=1; ack_seen[i] set sticky on opp_ack[i]; player_unready -> IDLE (highest priority).
REQ-021 GAME_READY: when ack_seen|opp_ack is all ones -> COUNTDOWN, loading the countdown timer.
REQ-022 GAME_READY: timer counts cycles in state; at READY_TIMEOUT-1 without all acks -> IDLE with ready_timeout=1 for that one cycle.
REQ-023 All acks arriving in the same cycle as the timeout SHALL win: -> COUNTDOWN, no pulse.
REQ-024 COUNTDOWN: send_ready_ACK=1 (opponents still syncing); after exactly COUNTDOWN cycles -> IN_GAME with opp_alive set to all ones; player_unready -> IDLE.
REQ-025 IN_GAME: game_active=1; opp_lost[i] clears opp_alive[i]; cleared bits never re-set until next game.
REQ-026 IN_GAME: top_out -> GAME_LOST, place = popcount(opp_alive & ~opp_lost) + 1.
REQ-027 IN_GAME: all opponents cleared (including this cycle) with no top_out -> GAME_WON, place = 1.
REQ-028 Simultaneous top_out and final opponent loss SHALL resolve as GAME_LOST with place = 1+0 = 1 (tie counts as shared first; game_won stays 0).
REQ-029 IN_GAME: player_unready -> GAME_LOST (forfeit), same place rule.
REQ-030 GAME_LOST: send_game_lost=1; keep tracking opp_lost; when opp_alive reaches zero -> IDLE.
REQ-031 GAME_WON: game_won=1; player_ready or player_unready -> IDLE.
REQ-032 Timer SHALL be $clog2(max(READY_TIMEOUT,COUNTDOWN)+1) bits wide, saturating, never wrapping.
REQ-033 opp_ack and opp_lost bits SHALL be ignored in states where they are not listed above.

Reset
REQ-034 rst_l low SHALL asynchronously force IDLE, timer=0, ack_seen=0, opp_alive=0, place=0, and all outputs 0.
REQ-035 Reset mid-game SHALL abandon the game with no game-lost sent; the first state after deassertion is IDLE.

Structure
REQ-036 sync_state_t enum and default timing constants SHALL live in NetworkPkg.
REQ-037 Population count SHALL be a sub-module, popcount, parametrised on width.

Verification (NUM_OPP=3, READY_TIMEOUT=16, COUNTDOWN=4)
REQ-038 player_ready, opp_ack pulses 001,100,010 on separate cycles -> COUNTDOWN after third; game_active rises exactly 4 cycles later; opp_alive=111.
REQ-039 player_ready, only opp_ack=011 -> ready_timeout pulse 16 cycles after GAME_READY entry, state IDLE; acks all arrive on cycle 15 -> no pulse, COUNTDOWN.
REQ-040 In game: opp_lost 010, then top_out -> place=3, send_game_lost=1; then opp_lost 101 -> IDLE, place holds 3.
REQ-041 In game: opp_lost 001, 100, then 010 -> game_won=1, place=1; top_out together with final 010 -> GAME_LOST, place=1.
REQ-042 rst_l low during IN_GAME and during COUNTDOWN -> all outputs 0 immediately (same cycle, asynchronously); IDLE after release.
